// File: rtl/onchip_mem_stream_reader_if.sv
// Bundles the RAM read port and the AXI-Stream output of the stream reader.
// The reader is the master of both the RAM port and the stream.
interface onchip_mem_stream_reader_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) ();
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [1:0]        mem_byteenable;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    input  mem_readdata,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    output mem_readdata,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/onchip_mem_stream_reader.sv
// Streams a contiguous block of RAM words out over AXI-Stream. A read is only issued
// when the skid FIFO is guaranteed to have room for its data one cycle later.
module onchip_mem_stream_reader #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W:0]   length_i,
  output logic              busy_o,
  output logic              done_o,
  onchip_mem_stream_reader_if.master bus_if
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   REM_ZERO  = (ADDR_W + 1)'(0);
  localparam logic [CNT_W:0]    OCC_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ZERO  = PTR_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              done_q, done_d;
  logic              inflight_q, inflight_last_q;

  // Each FIFO entry carries the word plus its end-of-job marker in the top bit.
  logic [DATA_W:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic              issue_s;
  logic              push_s;
  logic              pop_s;
  logic              tvalid_s;
  logic              tlast_s;
  logic              credit_s;
  logic [CNT_W:0]    occupancy_s;

  assign occupancy_s = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign credit_s    = (occupancy_s < OCC_LIMIT);
  assign tvalid_s    = (count_q != CNT_ZERO);
  assign tlast_s     = tvalid_s & fifo_mem_q[rd_ptr_q][DATA_W];
  assign push_s      = inflight_q;
  assign pop_s       = tvalid_s & bus_if.m_axis_tready;

  assign bus_if.mem_address    = issue_s ? next_addr_q : last_addr_q;
  assign bus_if.mem_chipselect = issue_s;
  assign bus_if.mem_write      = 1'b0;
  assign bus_if.mem_byteenable = 2'b11;
  assign bus_if.mem_clken      = 1'b1;
  assign bus_if.m_axis_tvalid  = tvalid_s;
  assign bus_if.m_axis_tdata   = fifo_mem_q[rd_ptr_q][DATA_W-1:0];
  assign bus_if.m_axis_tlast   = tlast_s;
  assign busy_o                = (state_q != ST_IDLE);
  assign done_o                = done_q;

  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    last_addr_d = last_addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    issue_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (length_i != REM_ZERO) begin
            state_d     = ST_RUN;
            next_addr_d = start_addr_i;
            remaining_d = length_i;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (credit_s) begin
          issue_s     = 1'b1;
          last_addr_d = next_addr_q;
          next_addr_d = next_addr_q + ADDR_ONE;
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (pop_s && tlast_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= ST_IDLE;
      next_addr_q     <= {ADDR_W{1'b0}};
      last_addr_q     <= {ADDR_W{1'b0}};
      remaining_q     <= REM_ZERO;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      next_addr_q     <= next_addr_d;
      last_addr_q     <= last_addr_d;
      remaining_q     <= remaining_d;
      done_q          <= done_d;
      inflight_q      <= issue_s;
      inflight_last_q <= issue_s & (remaining_q == REM_ONE);
    end
  end

  // Read data lands one cycle after issue; the credit check guarantees a free slot.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= {inflight_last_q, bus_if.mem_readdata};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
